mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 54 +++++
 tb/tb_mem_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: owner encoding and default widths shared by the arbiter, its interface and bench
package mem_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LS} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory-port and debug signals; slave = arbiter side, master = requesters + memory side
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W = mem_arbiter_pkg::DATA_W
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [3:0]        starve_cnt;
  modport slave (
    input  fetch_req, fetch_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, starve_cnt
  );
  modport master (
    output fetch_req, fetch_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, starve_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch vs load/store arbiter onto one sync memory port with fetch anti-starvation; ports clk, reset_n, bus (mem_arbiter_if.slave)
module mem_arbiter #(
  parameter int ADDR_W     = mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W     = mem_arbiter_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus
);
  import mem_arbiter_pkg::*;
  logic [3:0]        r_starve;
  logic [3:0]        w_starve_nxt;
  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic              w_freq;
  logic              w_lreq;
  logic              w_fgnt;
  logic              w_lgnt;
  logic              w_force;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rdata;
  always_comb begin
    w_freq       = reset_n & bus.fetch_req;
    w_lreq       = reset_n & bus.ls_req;
    w_force      = r_starve == 4'(STARVE_MAX);
    w_fgnt       = w_freq & (~w_lreq | w_force);
    w_lgnt       = w_lreq & ~w_fgnt;
    w_addr       = w_fgnt ? bus.fetch_addr : bus.ls_addr;
    w_starve_nxt = (w_freq & ~w_fgnt) ? (w_force ? r_starve : r_starve + 4'd1) : 4'd0;
    w_owner_nxt  = w_fgnt ? OWN_FETCH : (w_lgnt & ~bus.ls_we) ? OWN_LS : OWN_NONE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
      r_owner  <= OWN_NONE;
    end else begin
      r_starve <= w_starve_nxt;
      r_owner  <= w_owner_nxt;
    end
  end
  assign w_rdata          = bus.mem_rdata;
  assign bus.fetch_gnt    = w_fgnt;
  assign bus.ls_gnt       = w_lgnt;
  assign bus.mem_en       = w_fgnt | w_lgnt;
  assign bus.mem_we       = w_lgnt & bus.ls_we;
  assign bus.mem_addr     = w_addr;
  assign bus.mem_wdata    = bus.ls_wdata;
  assign bus.fetch_rdata  = w_rdata;
  assign bus.ls_rdata     = w_rdata;
  assign bus.fetch_rvalid = r_owner == OWN_FETCH;
  assign bus.ls_rvalid    = r_owner == OWN_LS;
  assign bus.starve_cnt   = r_starve;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with memory model, reference arbiter and per-cycle rvalid expectations
module tb_mem_arbiter;
  localparam int SM = 4;
  typedef struct packed {
    logic        fv;
    logic        lv;
    logic [15:0] d;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          m_starve = 0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic check_rv();
    exp_t e;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("fetch_rvalid", 32'(bus.fetch_rvalid), 32'(e.fv));
      chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(e.lv));
      if (e.fv) chk("fetch_rdata", 32'(bus.fetch_rdata), 32'(e.d));
      if (e.lv) chk("ls_rdata", 32'(bus.ls_rdata), 32'(e.d));
    end
  endtask
  task automatic step(input logic f, input logic [15:0] fa, input logic l, input logic we,
                      input logic [15:0] la, input logic [15:0] wd);
    logic fg, lg;
    exp_t e;
    @(negedge clk);
    check_rv();
    bus.fetch_req  = f;
    bus.fetch_addr = fa;
    bus.ls_req     = l;
    bus.ls_we      = we;
    bus.ls_addr    = la;
    bus.ls_wdata   = wd;
    #1;
    fg = f && (!l || m_starve == SM);
    lg = l && !fg;
    chk("fetch_gnt", 32'(bus.fetch_gnt), 32'(fg));
    chk("ls_gnt", 32'(bus.ls_gnt), 32'(lg));
    chk("mem_en", 32'(bus.mem_en), 32'(fg || lg));
    chk("mem_we", 32'(bus.mem_we), 32'(lg && we));
    chk("starve_cnt", 32'(bus.starve_cnt), 32'(m_starve));
    if (fg || lg) chk("mem_addr", 32'(bus.mem_addr), 32'(fg ? fa : la));
    if (lg && we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
    e.fv = fg;
    e.lv = lg && !we;
    e.d  = fg ? ref_mem[fa] : ref_mem[la];
    sb.push_back(e);
    if (lg && we) ref_mem[la] = wd;
    m_starve = (f && !fg) ? ((m_starve == SM) ? SM : m_starve + 1) : 0;
  endtask
  task automatic rst_checks(input string tag);
    chk({tag, "_fetch_gnt"}, 32'(bus.fetch_gnt), 32'd0);
    chk({tag, "_ls_gnt"}, 32'(bus.ls_gnt), 32'd0);
    chk({tag, "_fetch_rvalid"}, 32'(bus.fetch_rvalid), 32'd0);
    chk({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid), 32'd0);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_starve"}, 32'(bus.starve_cnt), 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    rst_checks("midrst");
    bus.fetch_req = 1'b0;
    bus.ls_req    = 1'b0;
    m_starve      = 0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back('0);
  endtask
  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
    mem[16'h0010]     = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    repeat (2) @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.ls_req    = 1'b1;
    #1;
    rst_checks("rst");
    bus.fetch_req = 1'b0;
    bus.ls_req    = 1'b0;
    reset_n       = 1'b1;
    sb.push_back('0);
    step(1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    step(0, 16'h0000, 1, 1, 16'h0020, 16'h1234);
    step(0, 16'h0000, 1, 0, 16'h0020, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    repeat (12) step(1, 16'h0030, 1, 0, 16'h0040, 16'h0000);
    for (int i = 0; i < 8; i++)
      step(i % 2 == 0, 16'(16'h0050 + i), i % 2 == 1, 0, 16'(16'h0060 + i), 16'h0000);
    step(1, 16'h0070, 1, 0, 16'h0080, 16'h0000);
    step(1, 16'h0070, 1, 0, 16'h0080, 16'h0000);
    step(0, 16'h0000, 1, 0, 16'h0081, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    step(0, 16'h0000, 1, 0, 16'h0020, 16'h0000);
    do_reset();
    step(1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
    step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    repeat (60)
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom));
    step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_rv();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
